// File: rtl/score_pkg.sv
// score_pkg
// Shared definitions for the game-tick score counter:
//   - state_e  : game-state FSM encoding (IDLE, RUN, OVER)
//   - BCD_MAX  : saturation value of the 4-digit BCD score
//   - DIGITS   : number of BCD digits in a score word
package score_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  localparam logic [15:0] BCD_MAX = 16'h9999;
  localparam int          DIGITS  = 4;

endpackage : score_pkg

// File: rtl/bcd_inc4.sv
// bcd_inc4
// Purely combinational 4-digit packed-BCD incrementer with saturation.
// Ports:
//   value_i [15:0] : current BCD value ([15:12] thousands .. [3:0] units)
//   value_o [15:0] : value_i + 1 in BCD, or value_i unchanged when it is 9999
module bcd_inc4
  import score_pkg::*;
(
  input  logic [15:0] value_i,
  output logic [15:0] value_o
);

  logic [15:0] sum_s;
  logic        carry_s;
  logic [3:0]  digit_s;

  // Ripple a +1 carry through the digits, wrapping each 9 to 0.
  always_comb begin
    sum_s   = value_i;
    carry_s = 1'b1;
    digit_s = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digit_s = value_i[4*i +: 4];
      if (carry_s) begin
        if (digit_s == 4'd9) begin
          sum_s[4*i +: 4] = 4'd0;
          carry_s         = 1'b1;
        end else begin
          sum_s[4*i +: 4] = digit_s + 4'd1;
          carry_s         = 1'b0;
        end
      end else begin
        sum_s[4*i +: 4] = digit_s;
      end
    end
  end

  // 9999 would otherwise wrap to 0000; hold it instead.
  assign value_o = (value_i == BCD_MAX) ? value_i : sum_s;

endmodule : bcd_inc4

// File: rtl/score_tick_counter.sv
// score_tick_counter
// Consumes the 25 Hz game-tick pulse, prescales it into score points and
// keeps a 4-digit BCD run score plus a session high score.
// Parameters:
//   TICKS_PER_POINT : tick rising edges per score point, legal range 1..255
// Ports:
//   clk_in    : system clock (same clock as the tick divider)
//   rst_n     : asynchronous active-low reset
//   tick      : divider output; only its rising edge counts
//   start     : start / restart request, level-sampled
//   hit       : collision, level-sampled
//   score     : current run score, BCD
//   hi_score  : best score since reset, BCD
//   running   : high while in RUN
//   game_over : high while in OVER
//   new_high  : one-cycle pulse when hi_score is replaced
module score_tick_counter
  import score_pkg::*;
#(
  parameter int TICKS_PER_POINT = 5
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        start,
  input  logic        hit,
  output logic [15:0] score,
  output logic [15:0] hi_score,
  output logic        running,
  output logic        game_over,
  output logic        new_high
);

  localparam logic [7:0] PS_LAST = 8'(TICKS_PER_POINT - 1);

  state_e      state_q, state_d;
  logic [7:0]  prescale_q, prescale_d;
  logic        tick_dly_q;
  logic [15:0] score_q, score_d;
  logic [15:0] hi_q, hi_d;
  logic        new_high_q, new_high_d;
  logic        running_q, game_over_q;
  logic        tick_rise;
  logic [15:0] score_inc;

  assign tick_rise = tick & ~tick_dly_q;

  bcd_inc4 u_inc (
    .value_i (score_q),
    .value_o (score_inc)
  );

  // Next-state logic for the game FSM, prescaler, score and high score.
  always_comb begin
    state_d    = state_q;
    prescale_d = prescale_q;
    score_d    = score_q;
    hi_d       = hi_q;
    new_high_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        // start wins over hit; a tick in the start cycle is discarded.
        if (start) begin
          state_d    = ST_RUN;
          score_d    = 16'h0000;
          prescale_d = 8'd0;
        end else begin
          state_d    = state_q;
        end
      end
      ST_RUN: begin
        // hit has priority over a scoring tick, so the compare sees the
        // pre-tick score.
        if (hit) begin
          state_d = ST_OVER;
          if (score_q > hi_q) begin
            hi_d       = score_q;
            new_high_d = 1'b1;
          end else begin
            hi_d       = hi_q;
          end
        end else if (tick_rise) begin
          if (prescale_q == PS_LAST) begin
            prescale_d = 8'd0;
            score_d    = score_inc;
          end else begin
            prescale_d = prescale_q + 8'd1;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        // Unused encoding: fall back to a safe idle.
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; status flags registered from next state.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      prescale_q  <= 8'd0;
      tick_dly_q  <= 1'b0;
      score_q     <= 16'h0000;
      hi_q        <= 16'h0000;
      new_high_q  <= 1'b0;
      running_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prescale_q  <= prescale_d;
      tick_dly_q  <= tick;
      score_q     <= score_d;
      hi_q        <= hi_d;
      new_high_q  <= new_high_d;
      running_q   <= (state_d == ST_RUN);
      game_over_q <= (state_d == ST_OVER);
    end
  end

  assign score     = score_q;
  assign hi_score  = hi_q;
  assign running   = running_q;
  assign game_over = game_over_q;
  assign new_high  = new_high_q;

endmodule : score_tick_counter

// File: tb/tb_score_tick_counter.sv
// Directed testbench for score_tick_counter. The main instance uses the
// default five ticks per point; a second instance with one tick per point
// makes the saturation run short.
module tb_score_tick_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0, start = 1'b0, hit = 1'b0;
  logic        tick1 = 1'b0, start1 = 1'b0, hit1 = 1'b0;
  logic [15:0] score, hi_score, score1, hi_score1;
  logic        running, game_over, new_high;
  logic        running1, game_over1, new_high1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  score_tick_counter dut (
    .clk_in(clk), .rst_n(rst_n), .tick(tick), .start(start), .hit(hit),
    .score(score), .hi_score(hi_score), .running(running),
    .game_over(game_over), .new_high(new_high)
  );

  score_tick_counter #(.TICKS_PER_POINT(1)) dut1 (
    .clk_in(clk), .rst_n(rst_n), .tick(tick1), .start(start1), .hit(hit1),
    .score(score1), .hi_score(hi_score1), .running(running1),
    .game_over(game_over1), .new_high(new_high1)
  );

  task automatic pulse_tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
    end
  endtask

  task automatic pulse_tick1(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) tick1 = 1'b1;
      @(negedge clk) tick1 = 1'b0;
    end
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic do_hit();
    @(negedge clk) hit = 1'b1;
    @(negedge clk) hit = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({score, hi_score, running, game_over, new_high} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h/%h r%b g%b n%b required all 0",
               score, hi_score, running, game_over, new_high);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_count();
    do_start();
    checks++;
    if (score !== 16'h0000 || running !== 1'b1) begin
      errors++;
      $display("FAIL start_run: got score=%h running=%b required 0000/1", score, running);
    end
    pulse_tick(4);
    @(negedge clk) tick = 1'b1;
    @(negedge clk);
    checks++;
    if (score !== 16'h0001) begin
      errors++;
      $display("FAIL tick_latency: got %h required 0001", score);
    end
    tick = 1'b0;
    pulse_tick(20);
    checks++;
    if (score !== 16'h0005 || running !== 1'b1 || hi_score !== 16'h0000) begin
      errors++;
      $display("FAIL basic_count: got score=%h run=%b hi=%h required 0005/1/0000",
               score, running, hi_score);
    end
  endtask

  task automatic test_bcd_carry();
    pulse_tick(94 * 5);
    checks++;
    if (score !== 16'h0099) begin
      errors++;
      $display("FAIL carry_0099: got %h required 0099", score);
    end
    pulse_tick(5);
    checks++;
    if (score !== 16'h0100) begin
      errors++;
      $display("FAIL carry_0100: got %h required 0100", score);
    end
  endtask

  task automatic test_saturate();
    // start together with a tick rise: that tick must not score
    @(negedge clk) begin start1 = 1'b1; tick1 = 1'b1; end
    @(negedge clk) begin start1 = 1'b0; tick1 = 1'b0; end
    checks++;
    if (score1 !== 16'h0000 || running1 !== 1'b1) begin
      errors++;
      $display("FAIL start_tick_same_cycle: got %h run=%b required 0000/1", score1, running1);
    end
    pulse_tick1(1000);
    checks++;
    if (score1 !== 16'h1000) begin
      errors++;
      $display("FAIL carry_1000: got %h required 1000", score1);
    end
    pulse_tick1(8999);
    checks++;
    if (score1 !== 16'h9999) begin
      errors++;
      $display("FAIL reach_9999: got %h required 9999", score1);
    end
    pulse_tick1(10);
    checks++;
    if (score1 !== 16'h9999 || running1 !== 1'b1) begin
      errors++;
      $display("FAIL saturate: got %h run=%b required 9999/1", score1, running1);
    end
  endtask

  task automatic test_game_over();
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    do_start();
    pulse_tick(42 * 5);
    do_hit();
    checks++;
    if (game_over !== 1'b1 || running !== 1'b0 || hi_score !== 16'h0042 ||
        new_high !== 1'b1 || score !== 16'h0042) begin
      errors++;
      $display("FAIL hit_new_high: got go=%b run=%b hi=%h nh=%b score=%h required 1/0/0042/1/0042",
               game_over, running, hi_score, new_high, score);
    end
    @(negedge clk);
    checks++;
    if (new_high !== 1'b0) begin
      errors++;
      $display("FAIL new_high_width: got %b required 0", new_high);
    end
    do_start();
    pulse_tick(30 * 5);
    checks++;
    if (score !== 16'h0030) begin
      errors++;
      $display("FAIL second_run: got %h required 0030", score);
    end
    do_hit();
    checks++;
    if (hi_score !== 16'h0042 || new_high !== 1'b0 || game_over !== 1'b1) begin
      errors++;
      $display("FAIL lower_score: got hi=%h nh=%b go=%b required 0042/0/1",
               hi_score, new_high, game_over);
    end
  endtask

  task automatic test_simultaneous();
    do_start();
    pulse_tick(7 * 5 + 4);
    @(negedge clk) begin tick = 1'b1; hit = 1'b1; end
    @(negedge clk) begin tick = 1'b0; hit = 1'b0; end
    checks++;
    if (score !== 16'h0007 || game_over !== 1'b1 || new_high !== 1'b0 ||
        hi_score !== 16'h0042) begin
      errors++;
      $display("FAIL hit_with_tick: got score=%h go=%b nh=%b hi=%h required 0007/1/0/0042",
               score, game_over, new_high, hi_score);
    end
    @(negedge clk) begin start = 1'b1; hit = 1'b1; end
    @(negedge clk) begin start = 1'b0; hit = 1'b0; end
    checks++;
    if (running !== 1'b1 || game_over !== 1'b0 || score !== 16'h0000) begin
      errors++;
      $display("FAIL start_and_hit: got run=%b go=%b score=%h required 1/0/0000",
               running, game_over, score);
    end
  endtask

  task automatic test_long_tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) tick = 1'b1;
      repeat (10) @(negedge clk);
      tick = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (score !== 16'h0001) begin
      errors++;
      $display("FAIL long_tick: got %h required 0001", score);
    end
  endtask

  task automatic test_async_reset();
    do_hit();
    do_start();
    pulse_tick(200 * 5);
    do_hit();
    checks++;
    if (hi_score !== 16'h0200 || new_high !== 1'b1) begin
      errors++;
      $display("FAIL hi_0200: got hi=%h nh=%b required 0200/1", hi_score, new_high);
    end
    do_start();
    pulse_tick(123 * 5);
    checks++;
    if (score !== 16'h0123 || hi_score !== 16'h0200 || running !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got score=%h hi=%h run=%b required 0123/0200/1",
               score, hi_score, running);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({score, hi_score, running, game_over, new_high} !== 35'd0) begin
      errors++;
      $display("FAIL async_reset: got %h/%h r%b g%b n%b required all 0",
               score, hi_score, running, game_over, new_high);
    end
    @(negedge clk) rst_n = 1'b1;
    pulse_tick(5);
    checks++;
    if (running !== 1'b0 || game_over !== 1'b0 || score !== 16'h0000) begin
      errors++;
      $display("FAIL idle_after_reset: got run=%b go=%b score=%h required 0/0/0000",
               running, game_over, score);
    end
    do_start();
    checks++;
    if (running !== 1'b1 || hi_score !== 16'h0000) begin
      errors++;
      $display("FAIL start_after_reset: got run=%b hi=%h required 1/0000", running, hi_score);
    end
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_bcd_carry();
    test_saturate();
    test_game_over();
    test_simultaneous();
    test_long_tick();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_score_tick_counter
